pc_fetch_sequencer: RTL and testbench

- Controller that sequences the 16-bit program counter register and the instruction fetch around it.
- Drives the PC register's next-value input every cycle and runs the instruction-memory request/acknowledge handshake.
- Hands fetched instructions to decode with a valid/ready handshake.
- Handles branch/jump redirects, HLT, and one level of interrupt entry/return (EPC save/restore).

---
 rtl/pc_fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter / instruction-fetch sequencer: steers the external PC register,
// runs the imem request/ack exchange, and presents fetched words to decode.
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0004,
  parameter logic [15:0] PC_STEP      = 16'h0001,
  parameter logic        IE_RESET     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc_current,
  output logic [15:0] pc_next,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic        eret,
  input  logic        halt,
  input  logic        irq,
  output logic        irq_ack,
  output logic [15:0] epc,
  output logic        running,
  output logic [1:0]  dbg_state
);

  // Decode handshake: instr/instr_pc are offered while instr_valid is high and are
  // consumed on any clock edge where instr_valid && instr_ready; until then they hold.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ie_q, ie_d;
  logic [15:0] epc_d, instr_d, instr_pc_d;
  logic        take_irq;

  assign imem_addr = pc_current;
  assign dbg_state = state_q;
  assign take_irq  = irq && ie_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      ie_q     <= IE_RESET;
      epc      <= 16'h0000;
      instr    <= 16'h0000;
      instr_pc <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      epc      <= epc_d;
      instr    <= instr_d;
      instr_pc <= instr_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_next     = pc_current;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    irq_ack     = 1'b0;
    running     = 1'b1;
    ie_d        = ie_q;
    epc_d       = epc;
    instr_d     = instr;
    instr_pc_d  = instr_pc;
    case (state_q)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // A redirect or interrupt entry abandons the outstanding request, ack or not.
        if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (take_irq) begin
          epc_d   = pc_current;
          pc_next = IRQ_VECTOR;
          ie_d    = 1'b0;
          irq_ack = 1'b1;
        end else if (imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = pc_current;
          pc_next    = pc_current + PC_STEP;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          pc_next = redirect_target;
          state_d = FETCH;
        end else if (instr_ready && eret) begin
          pc_next = epc;
          ie_d    = 1'b1;
          state_d = FETCH;
        end else if (instr_ready && halt) begin
          state_d = HALTED;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        running = 1'b0;
        // PC already points past the HLT, so that is the return address saved here.
        if (take_irq) begin
          epc_d   = pc_current;
          pc_next = IRQ_VECTOR;
          ie_d    = 1'b0;
          irq_ack = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomised bench for pc_fetch_sequencer: bench-side PC register and memory,
// an instruction-level architectural model, and a queue-based scoreboard.
module tb_pc_fetch_sequencer;

  localparam logic [15:0] RV  = 16'h0000;
  localparam logic [15:0] IV  = 16'h0004;
  localparam logic [15:0] XKEY = 16'hA500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_current = 16'h1234;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr, instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        eret = 1'b0, halt = 1'b0, irq = 1'b0;
  logic        irq_ack;
  logic [15:0] epc;
  logic        running;
  logic [1:0]  dbg_state;

  pc_fetch_sequencer dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .eret(eret), .halt(halt), .irq(irq), .irq_ack(irq_ack), .epc(epc),
    .running(running), .dbg_state(dbg_state)
  );

  // clock / PC register (the PC register has no reset of its own)
  always #5 clock = ~clock;
  always @(posedge clock) pc_current <= pc_next;

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_q[$];
  logic [15:0] irq_q[$];

  // architectural model: address of the next instruction decode should see
  logic [15:0] m_pc, m_epc;
  logic        m_ie, m_halted;
  int          idle, halt_cnt, hold_len, stall;
  logic        in_issue;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check16(name, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] pick_target();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h0040;
      2: return 16'hFFFE;
      3: return 16'h0010;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic replace_expected();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(m_pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check16("rst_state", {14'b0, dbg_state}, 16'h0000);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check16("rst_instr", instr, 16'h0000);
    check16("rst_instr_pc", instr_pc, 16'h0000);
    check16("rst_epc", epc, 16'h0000);
    check1("rst_irq_ack", irq_ack, 1'b0);
    check1("rst_imem_req", imem_req, 1'b0);
    check16("rst_pc_next", pc_next, RV);
    @(negedge clock);
    reset = 1'b0;
    m_pc = RV; m_epc = 16'h0000; m_ie = 1'b1; m_halted = 1'b0;
    in_issue = 1'b0; idle = 0; stall = 0;
    exp_q.delete();
    irq_q.delete();
    exp_q.push_back(RV);
    @(posedge clock);
    #1;
    check1("boot_req", imem_req, 1'b1);
    check16("boot_addr", imem_addr, RV);
  endtask

  // memory: random 0..3 cycle latency, word = address ^ A500, restarts on address change
  initial begin
    logic        busy;
    logic [15:0] cur;
    int          wt;
    busy = 1'b0; cur = 16'h0000; wt = 0;
    forever begin
      @(negedge clock);
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      if (!imem_req) begin
        busy = 1'b0;
      end else begin
        if (!busy || imem_addr != cur) begin
          busy = 1'b1;
          cur  = imem_addr;
          wt   = $urandom_range(0, 3);
        end
        if (wt == 0) begin
          imem_ack  = 1'b1;
          imem_data = cur ^ XKEY;
          busy      = 1'b0;
        end else begin
          wt--;
        end
      end
    end
  end

  // monitor: pops expectations when a new instruction or an irq_ack appears
  initial begin
    logic        prev_v;
    logic        epc_pend;
    logic [15:0] epc_exp, e;
    prev_v = 1'b0; epc_pend = 1'b0; epc_exp = 16'h0000;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_v = 1'b0;
        epc_pend = 1'b0;
      end else begin
        if (epc_pend) begin
          check16("epc", epc, epc_exp);
          epc_pend = 1'b0;
        end
        if (instr_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_instr");
          end else begin
            e = exp_q.pop_front();
            check16("instr_pc", instr_pc, e);
            check16("instr", instr, e ^ XKEY);
          end
        end
        prev_v = instr_valid;
        if (irq_ack) begin
          if (irq_q.size() == 0) begin
            fail_now("unexpected_irq_ack");
          end else begin
            epc_exp  = irq_q.pop_front();
            epc_pend = 1'b1;
          end
        end
      end
    end
  end

  // driver: one decision per cycle, model updated at instruction granularity
  initial begin
    int r;
    logic [15:0] tgt;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      instr_ready = 1'b0; redirect_valid = 1'b0; eret = 1'b0; halt = 1'b0; irq = 1'b0;
      redirect_target = 16'($urandom);
      if (m_halted) begin
        check1("halted_running", running, 1'b0);
        check1("halted_req", imem_req, 1'b0);
        check16("halted_pc", pc_current, m_pc);
        halt_cnt++;
        if (halt_cnt >= hold_len) begin
          if (m_ie) begin
            irq = 1'b1;
            irq_q.push_back(m_pc);
            m_epc = m_pc; m_pc = IV; m_ie = 1'b0; m_halted = 1'b0;
            exp_q.push_back(IV);
          end else if (halt_cnt < hold_len + 3) begin
            irq = 1'b1;
          end else begin
            do_reset();
          end
        end
      end else if (instr_valid) begin
        if (!in_issue) begin
          in_issue = 1'b1;
          idle = 0;
          stall = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 2);
        end
        check16("issue_instr_pc", instr_pc, m_pc);
        check1("issue_req", imem_req, 1'b0);
        check16("issue_pc_hold", pc_current, 16'(m_pc + 16'd1));
        if (stall > 0) begin
          stall--;
          r = $urandom_range(0, 3);
          eret = (r == 0);
          halt = (r == 1);
        end else begin
          r = $urandom_range(0, 99);
          in_issue = 1'b0;
          if (r < 2) begin
            do_reset();
          end else begin
            if (r < 12) begin
              tgt = pick_target();
              redirect_valid = 1'b1;
              redirect_target = tgt;
              instr_ready = 1'($urandom_range(0, 1));
              eret = 1'($urandom_range(0, 1));
              m_pc = tgt;
            end else if (r < 27 && !m_ie) begin
              instr_ready = 1'b1; eret = 1'b1;
              m_pc = m_epc; m_ie = 1'b1;
            end else if (r < 32) begin
              instr_ready = 1'b1; halt = 1'b1;
              m_pc = 16'(m_pc + 16'd1); m_halted = 1'b1;
              halt_cnt = 0; hold_len = $urandom_range(2, 20);
            end else begin
              instr_ready = 1'b1;
              m_pc = 16'(m_pc + 16'd1);
            end
            if (!m_halted) exp_q.push_back(m_pc);
          end
        end
      end else if (imem_req) begin
        check16("fetch_addr", imem_addr, m_pc);
        idle++;
        r = $urandom_range(0, 99);
        if (r < 6) begin
          tgt = pick_target();
          redirect_valid = 1'b1;
          redirect_target = tgt;
          irq = 1'($urandom_range(0, 1));
          m_pc = tgt;
          replace_expected();
        end else if (r < 12) begin
          irq = 1'b1;
          if (m_ie) begin
            irq_q.push_back(m_pc);
            m_epc = m_pc; m_pc = IV; m_ie = 1'b0;
            replace_expected();
          end
        end else if (r < 13) begin
          do_reset();
        end
      end else begin
        idle++;
      end
      if (idle > 60) begin
        fail_now("no_progress");
        do_reset();
      end
    end
    @(negedge clock);
    instr_ready = 1'b0; redirect_valid = 1'b0; eret = 1'b0; halt = 1'b0; irq = 1'b0;
    repeat (3) @(negedge clock);
    check16("irq_q_drained", 16'(irq_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
